dadda_mac_acc: RTL
==================

Name: dadda_mac_acc

Overview:
Sequential accumulator directly downstream of the 16x16 unsigned dadda multiplier. It consumes a programmed number of 32-bit products over a valid/ready handshake and sums them into a wide accumulator. It then presents the sum on a result valid/ready handshake. Together with the multiplier it forms the team's multiply-accumulate datapath.

Parameters:
PROD_W, 32, product width; matches the multiplier output.
ACC_W, 40, accumulator width; must be >= PROD_W+1.
CNT_W, 8, width of the term-count field; at most 2^CNT_W-1 terms per run.

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a run; sampled only in IDLE
len  input  CNT_W  number of products to accumulate; latched on accepted start
busy  output  1  high in ACCUM and DONE
prod_valid  input  1  upstream product valid
prod  input  PROD_W  unsigned product from the multiplier
prod_ready  output  1  block accepts a product this cycle
acc_valid  output  1  result valid
acc_ready  input  1  downstream accepts the result
acc  output  ACC_W  accumulated sum, unsigned
ovf  output  1  sticky overflow flag for the current run

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- On rst, immediately and in any state: state=IDLE, acc=0, count=0, ovf=0, busy=0, prod_ready=0, acc_valid=0. An in-flight run is discarded.
- IDLE:
  - start=1 latches len, clears acc and ovf.
  - len!=0: go to ACCUM with count=len.
  - len==0: go directly to DONE with acc=0.
  - start=0: stay in IDLE; acc keeps the last result.
- ACCUM:
  - prod_ready=1, decoded from state with no combinational path from prod_valid.
  - A transfer occurs when prod_valid&&prod_ready: acc<=acc+zero-extended prod, and count decrements.
  - The transfer with count==1 moves to DONE.
  - Back-to-back transfers are allowed, one per cycle.
  - prod_valid=0 simply stalls; nothing changes.
- DONE:
  - acc_valid=1; acc and ovf are held stable.
  - acc_ready=1 moves to IDLE on the next edge, and acc_valid falls that edge.
  - prod_ready=0.
- start is ignored outside IDLE, including in the DONE cycle where acc_ready=1. A new start is honoured in the first IDLE cycle or later.
- Latency: acc_valid rises on the edge after the final transfer. A run of N terms with no stalls takes N+1 cycles from the start edge to acc_valid.
- Arithmetic: sums are modulo 2^ACC_W by default. ovf sets on any carry out of bit ACC_W-1 and stays set until the next accepted start.
- Upstream producers must hold prod stable while prod_valid=1 && prod_ready=0.

Optional Feature:
Macro: DADDA_MAC_SATURATE_EN.
- Defined: on carry out, acc clamps to all ones (2^ACC_W-1) and stays clamped for the rest of the run; ovf sets as normal.
- Undefined: wrap-around modulo 2^ACC_W; ovf still reports the carry.

Decomposition:
- Package dadda_pkg holds:
  - PROD_W, ACC_W and CNT_W default constants;
  - state enum: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
- One natural sub-module: dadda_sat_add, a combinational ACC_W-bit adder with carry output and clamp. The clamp is enabled by the macro.
- The FSM, counter and handshake logic stay in dadda_mac_acc.

Test Plan:
- Three-term run, len=3, products 361935522, 1030738330, 4294770690 sent back-to-back -> acc_valid one cycle after the third transfer; acc=5687444542; ovf=0.
- Empty run, start with len=0 -> acc_valid on the next edge; acc=0; prod_ready never high.
- Stalls and back-pressure, len=2 with prod_valid gaps of 3 cycles, acc_ready held low 5 cycles, start pulsed in DONE -> acc is stable throughout; the start is ignored; after acc_ready the block returns to IDLE.
- Overflow, ACC_W=33, len=3, prod=0xFFFFFFFF each -> wrap build: acc=0x0FFFFFFFD, ovf=1. SATURATE build: acc=0x1FFFFFFFF, ovf=1.
- Maximum length, len=255 of 0xFFFFFFFF -> acc=0xFEFFFFFF01; ovf=0; exactly 255 transfers accepted.
- Reset mid-run, rst asserted mid-cycle after 1 of 3 transfers -> all outputs 0 immediately; later products are refused until a new start.

Source files
------------

// File: rtl/dadda_pkg.sv
// Shared constants and state encoding for the dadda multiply-accumulate datapath.
package dadda_pkg;

    localparam int unsigned PROD_W_DEF = 32;
    localparam int unsigned ACC_W_DEF  = 40;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/dadda_sat_add.sv
// Combinational accumulator adder with carry out; optional clamp to all ones
// on carry when DADDA_MAC_SATURATE_EN is defined.
module dadda_sat_add #(
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned PROD_W = 32
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum_c,
    output logic              carry_c
);

    logic [ACC_W:0] raw;

    assign raw     = {1'b0, a} + (ACC_W+1)'(b);
    assign carry_c = raw[ACC_W];

`ifdef DADDA_MAC_SATURATE_EN
    assign sum_c = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
`else
    assign sum_c = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/dadda_mac_acc.sv
// Accumulates a programmed number of multiplier products and hands the sum
// downstream. Optional saturation: DADDA_MAC_SATURATE_EN (see dadda_sat_add).
module dadda_mac_acc
    import dadda_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_d;
    logic [ACC_W-1:0]   sum_c;
    logic               carry_c;

    dadda_sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .a       (acc),
        .b       (prod),
        .sum_c   (sum_c),
        .carry_c (carry_c)
    );

    // Next-state, counter and accumulator update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc;
        ovf_d   = ovf;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        state_d = ACCUM;
                        count_d = len;
                    end else begin
                        state_d = DONE;
                        count_d = '0;
                    end
                end
            end
            ACCUM: begin
                if (prod_valid && prod_ready) begin
                    acc_d   = sum_c;
                    ovf_d   = ovf | carry_c;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            prod_ready <= 1'b0;
            acc_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc        <= acc_d;
            ovf        <= ovf_d;
            busy       <= (state_d != IDLE);
            prod_ready <= (state_d == ACCUM);
            acc_valid  <= (state_d == DONE);
        end
    end

endmodule
